pu_buffer_ctrl: RTL and testbench

PU_BUFFER_CTRL -- requirements
Module: pu_buffer_ctrl

---
 rtl/pu_buffer_ctrl.sv | 125 ++++++++++++
 tb/tb_pu_buffer_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pu_buffer_ctrl.sv
// Ping-pong SPI-to-PU buffer controller: fills one bank from SPI bytes while the PU drains the other.
// Optional sticky error flags are built in when PU_BUFFER_CTRL_ERR_EN is defined.
module pu_buffer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_SIZE   = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  frame_end,
    input  logic                  rd_req,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_bank,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  frame_ready,
    output logic                  overflow,
    output logic                  underflow
);
    // state | meaning
    // IDLE  | fill bank empty, waiting for the first byte of a frame
    // RECV  | collecting bytes into the fill bank
    // HOLD  | frame complete, waiting for the PU to empty the drain bank
    // SWAP  | one-cycle bank exchange

    typedef enum logic [1:0] {IDLE, RECV, HOLD, SWAP} state_t;

    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(BUF_SIZE);

    state_t                state, state_nxt;
    logic                  ready_q;
    logic                  ready_edge;
    logic [ADDR_WIDTH:0]   fill_count;
    logic                  accept;
    logic                  drop;
    logic                  do_swap;
    logic                  drain;

    assign ready_edge = ready & ~ready_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ready_edge) state_nxt = RECV;
            RECV: if (frame_end)  state_nxt = (rd_count == '0) ? SWAP : HOLD;
            HOLD: if (rd_count == '0) state_nxt = SWAP;
            SWAP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept  = 1'b0;
        do_swap = 1'b0;
        if ((state == IDLE || state == RECV) && ready_edge && fill_count != FULL)
            accept = 1'b1;
        if (state == SWAP)
            do_swap = 1'b1;
        drop = ready_edge & ~accept;
    end

    assign drain = rd_req && (rd_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= 1'b0;
            fill_count <= '0;
            wr_bank    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_addr    <= '0;
            rd_count   <= '0;
        end else begin
            ready_q <= ready;
            wr_en   <= accept;
            if (accept) begin
                wr_addr    <= fill_count[ADDR_WIDTH-1:0];
                wr_data    <= data_in;
                fill_count <= fill_count + 1'b1;
            end
            // SWAP is only reached with an empty drain bank, so it never races a drain
            if (do_swap) begin
                wr_bank    <= ~wr_bank;
                rd_count   <= fill_count;
                fill_count <= '0;
                rd_addr    <= '0;
            end else if (drain) begin
                rd_addr  <= rd_addr + 1'b1;
                rd_count <= rd_count - 1'b1;
            end
        end
    end

    assign rd_bank     = ~wr_bank;
    assign frame_ready = (rd_count != '0);

`ifdef PU_BUFFER_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (drop)                      overflow  <= 1'b1;
            if (rd_req && rd_count == '0)  underflow <= 1'b1;
        end
    end
`else
    logic unused_err;
    assign unused_err = drop;
    assign overflow   = 1'b0;
    assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_pu_buffer_ctrl.sv
// Directed bench for pu_buffer_ctrl: fill/swap, drain, overflow, hold, coincident frame end and reset.
// Error-flag expectations follow PU_BUFFER_CTRL_ERR_EN.
module tb_pu_buffer_ctrl;
    logic       clk = 1'b0;
    logic       rst, ready, frame_end, rd_req;
    logic [7:0] data_in;
    logic       wr_en, wr_bank, rd_bank, frame_ready, overflow, underflow;
    logic [2:0] wr_addr, rd_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_count;

    int checks = 0;
    int errors = 0;

    logic [2:0] log_addr [64];
    logic [7:0] log_data [64];
    logic       log_bank [64];
    int         n_wr = 0;

`ifdef PU_BUFFER_CTRL_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    pu_buffer_ctrl dut (
        .clk(clk), .rst(rst), .ready(ready), .data_in(data_in), .frame_end(frame_end),
        .rd_req(rd_req), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_count(rd_count),
        .frame_ready(frame_ready), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en && n_wr < 64) begin
            log_addr[n_wr] = wr_addr;
            log_data[n_wr] = wr_data;
            log_bank[n_wr] = wr_bank;
            n_wr = n_wr + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ready = 1'b0; frame_end = 1'b0; rd_req = 1'b0; data_in = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] v, input int hold);
        data_in = v; ready = 1'b1;
        repeat (hold) step();
        ready = 1'b0;
        step();
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1; step();
        frame_end = 1'b0; step(); step();
    endtask

    task automatic read_one();
        rd_req = 1'b1; step();
        rd_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({wr_en, wr_bank, wr_addr, wr_data, rd_bank, rd_addr, rd_count, frame_ready, overflow, underflow}
            !== {1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s: wr_en=%b wr_bank=%b wr_addr=%0d wr_data=%0d rd_bank=%b rd_addr=%0d rd_count=%0d frame_ready=%b ovf=%b unf=%b, required all zero except rd_bank=1",
                     tag, wr_en, wr_bank, wr_addr, wr_data, rd_bank, rd_addr, rd_count, frame_ready, overflow, underflow);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_fill_swap();
        int base = n_wr;
        send_word(8'd2, 2);
        send_word(8'd3, 2);
        send_word(8'd4, 2);
        pulse_frame_end();
        checks++;
        if (n_wr - base !== 3) begin errors++; $display("FAIL fill_count_writes: got %0d required 3", n_wr - base); end
        for (int i = 0; i < 3 && base + i < n_wr; i++) begin
            checks++;
            if ({log_bank[base+i], log_addr[base+i], log_data[base+i]} !== {1'b0, 3'(i), 8'(i + 2)}) begin
                errors++;
                $display("FAIL fill_write%0d: bank=%b addr=%0d data=%0d required bank=0 addr=%0d data=%0d",
                         i, log_bank[base+i], log_addr[base+i], log_data[base+i], i, i + 2);
            end
        end
        checks++;
        if ({rd_bank, wr_bank, rd_count, frame_ready} !== {1'b0, 1'b1, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL fill_swap: rd_bank=%b wr_bank=%b rd_count=%0d frame_ready=%b required 0 1 3 1",
                     rd_bank, wr_bank, rd_count, frame_ready);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 3; i++) begin
            read_one();
            checks++;
            if ({rd_addr, rd_count} !== {3'(i), 4'(3 - i)}) begin
                errors++;
                $display("FAIL drain%0d: rd_addr=%0d rd_count=%0d required %0d %0d", i, rd_addr, rd_count, i, 3 - i);
            end
        end
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL drain_frame_ready: got %b required 0", frame_ready); end
        read_one();
        checks++;
        if ({rd_addr, rd_count, underflow} !== {3'd3, 4'd0, ERR}) begin
            errors++;
            $display("FAIL drain_underflow: rd_addr=%0d rd_count=%0d underflow=%b required 3 0 %b", rd_addr, rd_count, underflow, ERR);
        end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        base = n_wr;
        for (int v = 1; v <= 7; v++) send_word(8'(v), 1);
        checks++;
        if (n_wr - base !== 6) begin errors++; $display("FAIL ovf_writes: got %0d required 6", n_wr - base); end
        checks++;
        if (n_wr > base && {log_addr[n_wr-1], log_data[n_wr-1]} !== {3'd5, 8'd6}) begin
            errors++;
            $display("FAIL ovf_last_write: addr=%0d data=%0d required 5 6", log_addr[n_wr-1], log_data[n_wr-1]);
        end
        pulse_frame_end();
        checks++;
        if ({rd_count, overflow, rd_bank} !== {4'd6, ERR, 1'b0}) begin
            errors++;
            $display("FAIL ovf_result: rd_count=%0d overflow=%b rd_bank=%b required 6 %b 0", rd_count, overflow, rd_bank, ERR);
        end
    endtask

    task automatic test_hold();
        int base;
        do_reset();
        send_word(8'd8, 1);
        send_word(8'd9, 1);
        pulse_frame_end();
        base = n_wr;
        send_word(8'd5, 1);
        send_word(8'd6, 1);
        pulse_frame_end();
        send_word(8'd7, 1);
        checks++;
        if (n_wr - base !== 2) begin errors++; $display("FAIL hold_writes: got %0d required 2", n_wr - base); end
        checks++;
        if ({rd_bank, rd_count, overflow} !== {1'b0, 4'd2, ERR}) begin
            errors++;
            $display("FAIL hold_wait: rd_bank=%b rd_count=%0d overflow=%b required 0 2 %b", rd_bank, rd_count, overflow, ERR);
        end
        read_one();
        read_one();
        step(); step(); step();
        checks++;
        if ({rd_bank, rd_count, rd_addr, frame_ready} !== {1'b1, 4'd2, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL hold_swap: rd_bank=%b rd_count=%0d rd_addr=%0d frame_ready=%b required 1 2 0 1",
                     rd_bank, rd_count, rd_addr, frame_ready);
        end
    endtask

    task automatic test_coincide();
        int base;
        do_reset();
        base = n_wr;
        send_word(8'd1, 1);
        send_word(8'd2, 1);
        data_in = 8'd3; ready = 1'b1; frame_end = 1'b1;
        step();
        ready = 1'b0; frame_end = 1'b0;
        step(); step();
        checks++;
        if (n_wr - base !== 3) begin errors++; $display("FAIL coincide_writes: got %0d required 3", n_wr - base); end
        checks++;
        if (rd_count !== 4'd3 || rd_bank !== 1'b0) begin
            errors++;
            $display("FAIL coincide_count: rd_count=%0d rd_bank=%b required 3 0", rd_count, rd_bank);
        end
    endtask

    task automatic test_rst_mid_frame();
        do_reset();
        send_word(8'd4, 1);
        send_word(8'd5, 1);
        rst = 1'b1; step(); rst = 1'b0;
        check_reset_outputs("rst_mid_frame");
        pulse_frame_end();
        checks++;
        if ({rd_count, rd_bank, wr_bank, frame_ready} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_frame_end_ignored: rd_count=%0d rd_bank=%b wr_bank=%b frame_ready=%b required 0 1 0 0",
                     rd_count, rd_bank, wr_bank, frame_ready);
        end
    endtask

    initial begin
        test_reset();
        test_fill_swap();
        test_drain();
        test_overflow();
        test_hold();
        test_coincide();
        test_rst_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
